// File: rtl/qcl_pipe_pkg.sv
// Shared constants and helpers for the qcl_pipe credit link.
// Sizing helper gives the FIFO depth needed for full link throughput.
package qcl_pipe_pkg;

  localparam int unsigned credit_width_lp = 1;

  function automatic int unsigned req_els(
    input int unsigned fwd_stages,
    input int unsigned ret_stages
  );
    return fwd_stages + ret_stages + 2;
  endfunction

endpackage

// File: rtl/qcl_pipe_credit_rx_if.sv
// Beat/credit bundle between the link tail, the rx FIFO and its consumer.
// slave is the rx endpoint side; master is the pipe/consumer side.
interface qcl_pipe_credit_rx_if #(
  parameter int unsigned width_p = 32,
  parameter int unsigned els_p   = 8
);
  import qcl_pipe_pkg::*;

  localparam int unsigned cnt_width_lp = $clog2(els_p + 1);

  logic                       v_i;
  logic [width_p-1:0]         data_i;
  logic                       v_o;
  logic [width_p-1:0]         data_o;
  logic                       yumi_i;
  logic [credit_width_lp-1:0] credit_o;
  logic [cnt_width_lp-1:0]    count_o;
  logic                       ovf_o;
  logic [15:0]                ovf_cnt_o;

  modport slave (
    input  v_i, data_i, yumi_i,
    output v_o, data_o, credit_o,
    output count_o, ovf_o, ovf_cnt_o
  );

  modport master (
    output v_i, data_i, yumi_i,
    input  v_o, data_o, credit_o,
    input  count_o, ovf_o, ovf_cnt_o
  );

endinterface

// File: rtl/qcl_fifo_tracker.sv
// Pointer/occupancy tracker for the rx FIFO; works for any els_p >= 2.
// A full FIFO still accepts a beat when the head leaves in the same cycle.
module qcl_fifo_tracker #(
  parameter  int unsigned els_p        = 8,
  localparam int unsigned ptr_width_lp = $clog2(els_p),
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic                    yumi_i,
  output logic                    enq_o,
  output logic                    deq_o,
  output logic [ptr_width_lp-1:0] wptr_o,
  output logic [ptr_width_lp-1:0] rptr_o,
  output logic [cnt_width_lp-1:0] count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam logic [ptr_width_lp-1:0] last_lp =
    ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] els_lp =
    cnt_width_lp'(els_p);

  logic [ptr_width_lp-1:0] wptr_q, wptr_d;
  logic [ptr_width_lp-1:0] rptr_q, rptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(
    input logic [ptr_width_lp-1:0] p
  );
    return (p == last_lp) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == els_lp);
  assign empty_o = (count_q == '0);
  assign deq     = yumi_i & ~empty_o;
  assign enq     = v_i & (~full_o | deq);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq) wptr_d = ptr_inc(wptr_q);
    if (deq) rptr_d = ptr_inc(rptr_q);
    if (enq && !deq) count_d = count_q + 1'b1;
    if (deq && !enq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign enq_o   = enq;
  assign deq_o   = deq;
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

endmodule

// File: rtl/qcl_pipe_credit_rx.sv
// Receive endpoint of a credit-flow qcl_pipe link: FIFO, credit return, overflow.
// Define QCL_PIPE_CREDIT_RX_OVF_CNT_EN to build the dropped-beat counter.
module qcl_pipe_credit_rx
  import qcl_pipe_pkg::*;
#(
  parameter  int unsigned width_p      = 32,
  parameter  int unsigned els_p        = 8,
  localparam int unsigned ptr_width_lp = $clog2(els_p),
  localparam int unsigned cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  qcl_pipe_credit_rx_if.slave  link
);

  logic                    enq, deq, full, empty;
  logic [ptr_width_lp-1:0] wptr, rptr;
  logic [cnt_width_lp-1:0] count;
  logic                    ovf;
  logic                    credit_q, credit_d;
  logic                    ovf_q, ovf_d;
  logic [width_p-1:0]      mem_q [els_p];

  qcl_fifo_tracker #(
    .els_p (els_p)
  ) u_trk (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (link.v_i),
    .yumi_i    (link.yumi_i),
    .enq_o     (enq),
    .deq_o     (deq),
    .wptr_o    (wptr),
    .rptr_o    (rptr),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // Storage carries no reset; validity lives entirely in the tracker.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wptr] <= link.data_i;
  end

  assign ovf      = link.v_i & full & ~deq;
  assign credit_d = deq;
  assign ovf_d    = ovf_q | ovf;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      credit_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef QCL_PIPE_CREDIT_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ovf_cnt_q <= '0;
    else            ovf_cnt_q <= ovf_cnt_d;
  end

  assign link.ovf_cnt_o = ovf_cnt_q;
`else
  assign link.ovf_cnt_o = '0;
`endif

  assign link.v_o      = ~empty;
  assign link.data_o   = mem_q[rptr];
  assign link.credit_o = credit_width_lp'(credit_q);
  assign link.count_o  = count;
  assign link.ovf_o    = ovf_q;

endmodule
